// File: rtl/cpu_reg_pkg.sv
// Shared register-file constants, types and round-robin helper
// for the CPU writeback path.
package cpu_reg_pkg;

    localparam int CPU_ADDR_WIDTH    = 4;
    localparam int CPU_DATA_WIDTH    = 16;
    localparam int CPU_REG_FILE_SIZE = 16;

    typedef logic [CPU_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [CPU_DATA_WIDTH-1:0] reg_data_t;

    function automatic int unsigned rr_next(
        input int unsigned ptr,
        input int unsigned n
    );
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or
// after ptr (with wrap) wins. The pointer itself lives with the caller.
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any_gnt
);

    logic [W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((32'(ptr) + k) % N);
            if (!any_gnt && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                any_gnt   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write port owner: round-robin writeback arbitration,
// one-cycle registered write, and a busy scoreboard for RAW stalls.
module reg_wb_arbiter
    import cpu_reg_pkg::*;
#(
    parameter int ADDR_WIDTH    = CPU_ADDR_WIDTH,
    parameter int DATA_WIDTH    = CPU_DATA_WIDTH,
    parameter int REG_FILE_SIZE = CPU_REG_FILE_SIZE,
    parameter int NUM_REQ       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         reg_w_addr,
    output logic [DATA_WIDTH-1:0]         reg_w_data,
    output logic                          reg_w_en,
    input  logic                          claim_en,
    input  logic [ADDR_WIDTH-1:0]         claim_addr,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_1,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_2,
    output logic                          rd_busy_1,
    output logic                          rd_busy_2,
    output logic [REG_FILE_SIZE-1:0]      busy,
    output logic                          err_oob
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH:0] RF_LIMIT =
        (ADDR_WIDTH+1)'(REG_FILE_SIZE);

    logic [PTR_W-1:0]         rr_ptr;
    logic [NUM_REQ-1:0]       gnt;
    logic [PTR_W-1:0]         gnt_idx;
    logic                     any_gnt;
    logic [ADDR_WIDTH-1:0]    win_addr;
    logic [DATA_WIDTH-1:0]    win_data;
    logic                     win_ok;
    logic [REG_FILE_SIZE-1:0] claim_mask;
    logic [REG_FILE_SIZE-1:0] clear_mask;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign req_ready = gnt;

    // Grant is one-hot, so an AND-OR mux selects the winner.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_addr = win_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = win_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign win_ok = {1'b0, win_addr} < RF_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_w_en   <= 1'b0;
            reg_w_addr <= '0;
            reg_w_data <= '0;
            err_oob    <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            reg_w_en <= any_gnt && win_ok;
            err_oob  <= any_gnt && !win_ok;
            if (any_gnt) begin
                reg_w_addr <= win_addr;
                reg_w_data <= win_data;
                rr_ptr     <= PTR_W'(rr_next(32'(gnt_idx), NUM_REQ));
            end
        end
    end

    // Out-of-range addresses match no entry, so they are ignored for free.
    always_comb begin
        claim_mask = '0;
        clear_mask = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            claim_mask[i] = claim_en && (claim_addr == ADDR_WIDTH'(i));
            clear_mask[i] = reg_w_en && (reg_w_addr == ADDR_WIDTH'(i));
        end
    end

    // Set after clear: a claim in the write cycle keeps the entry busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clear_mask) | claim_mask;
        end
    end

    always_comb begin
        rd_busy_1 = 1'b0;
        rd_busy_2 = 1'b0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            if (rd_addr_1 == ADDR_WIDTH'(i)) rd_busy_1 = busy[i];
            if (rd_addr_2 == ADDR_WIDTH'(i)) rd_busy_2 = busy[i];
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: vector table, a reference
// model feeding an expected-write queue, and hand-written corner sequences.
module tb_reg_wb_arbiter;

    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int RFS = 12;
    localparam int NR  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [AW-1:0]    reg_w_addr;
    logic [DW-1:0]    reg_w_data;
    logic             reg_w_en;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;
    logic [AW-1:0]    rd_addr_1;
    logic [AW-1:0]    rd_addr_2;
    logic             rd_busy_1;
    logic             rd_busy_2;
    logic [RFS-1:0]   busy;
    logic             err_oob;

    always #5 clk = ~clk;

    reg_wb_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .REG_FILE_SIZE (RFS),
        .NUM_REQ       (NR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .reg_w_addr (reg_w_addr),
        .reg_w_data (reg_w_data),
        .reg_w_en   (reg_w_en),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_addr_1  (rd_addr_1),
        .rd_addr_2  (rd_addr_2),
        .rd_busy_1  (rd_busy_1),
        .rd_busy_2  (rd_busy_2),
        .busy       (busy),
        .err_oob    (err_oob)
    );

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } wr_t;

    typedef struct {
        logic [1:0]    valid;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          ce;
        logic [AW-1:0] ca;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [1:0]    x_ready;
        logic          x_b1;
        logic          x_b2;
    } vec_t;

    wr_t   exp_q[$];
    wr_t   m_w;
    logic [15:0] m_busy;
    int    m_ptr;
    int    checks   = 0;
    int    failures = 0;
    vec_t  tbl[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic m_rd(input logic [AW-1:0] a);
        return (int'(a) < RFS) ? m_busy[a] : 1'b0;
    endfunction

    function automatic int model_gnt();
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_w    = '{1'b0, '0, '0, 1'b0};
        m_busy = '0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [1:0] v, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    // One clock: check combinational outputs, advance the model at the
    // edge, then compare registered outputs with the queued expectation.
    task automatic cycle();
        wr_t e;
        wr_t got;
        int  g;
        logic [AW-1:0] a;
        #1;
        g = model_gnt();
        check("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
        check("rd_busy_1", 32'(rd_busy_1), 32'(m_rd(rd_addr_1)));
        check("rd_busy_2", 32'(rd_busy_2), 32'(m_rd(rd_addr_2)));
        @(posedge clk);
        if (m_w.en) m_busy[m_w.addr] = 1'b0;
        if (claim_en && int'(claim_addr) < RFS) m_busy[claim_addr] = 1'b1;
        if (g >= 0) begin
            a      = req_addr[g*AW +: AW];
            e.addr = a;
            e.data = req_data[g*DW +: DW];
            e.err  = (int'(a) >= RFS);
            e.en   = !e.err;
            m_ptr  = (g + 1) % NR;
        end else begin
            e     = m_w;
            e.en  = 1'b0;
            e.err = 1'b0;
        end
        m_w = e;
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check("reg_w_en",   32'(reg_w_en),   32'(got.en));
            check("reg_w_addr", 32'(reg_w_addr), 32'(got.addr));
            check("reg_w_data", 32'(reg_w_data), 32'(got.data));
            check("err_oob",    32'(err_oob),    32'(got.err));
            check("busy",       32'(busy),       32'(m_busy[RFS-1:0]));
        end
    endtask

    int fair_g[6];
    int en_cnt;
    logic [DW-1:0] fd0;
    logic [DW-1:0] fd1;

    initial begin
        tbl[0]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b1, 4'd5,  4'd5,  4'd3,  2'b00, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0,  4'd5,  4'd3,  2'b00, 1'b1, 1'b0};
        tbl[2]  = '{2'b01, 4'd5, 16'h1234, 4'd0, 16'h0000, 1'b0, 4'd0,  4'd5,  4'd3,  2'b01, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0,  4'd5,  4'd3,  2'b00, 1'b1, 1'b0};
        tbl[4]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0,  4'd5,  4'd3,  2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b01, 4'd5, 16'h5555, 4'd0, 16'h0000, 1'b0, 4'd0,  4'd5,  4'd3,  2'b01, 1'b0, 1'b0};
        tbl[6]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b1, 4'd5,  4'd5,  4'd3,  2'b00, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0,  4'd5,  4'd11, 2'b00, 1'b1, 1'b0};
        tbl[8]  = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b1, 4'd14, 4'd14, 4'd5,  2'b00, 1'b0, 1'b1};
        tbl[9]  = '{2'b11, 4'd1, 16'hAAAA, 4'd2, 16'hBBBB, 1'b0, 4'd0,  4'd1,  4'd2,  2'b10, 1'b0, 1'b0};
        tbl[10] = '{2'b11, 4'd1, 16'hAAAA, 4'd4, 16'hCCCC, 1'b0, 4'd0,  4'd1,  4'd4,  2'b01, 1'b0, 1'b0};
        tbl[11] = '{2'b10, 4'd0, 16'h0000, 4'd4, 16'hCCCC, 1'b0, 4'd0,  4'd4,  4'd1,  2'b10, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 1'b0, 4'd0,  4'd4,  4'd1,  2'b00, 1'b0, 1'b0};
        fair_g = '{0, 1, 0, 1, 0, 1};

        rst = 1'b1;
        drive(2'b00, '0, '0, '0, '0);
        claim_en   = 1'b0;
        claim_addr = '0;
        rd_addr_1  = '0;
        rd_addr_2  = '0;
        model_reset();

        #3;
        check("rst_reg_w_en",   32'(reg_w_en),   32'd0);
        check("rst_reg_w_addr", 32'(reg_w_addr), 32'd0);
        check("rst_reg_w_data", 32'(reg_w_data), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_err_oob",    32'(err_oob),    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester write to r3.
        drive(2'b01, 4'd3, 16'hBEEF, 4'd0, 16'h0000);
        cycle();
        check("single_en",   32'(reg_w_en),   32'd1);
        check("single_addr", 32'(reg_w_addr), 32'd3);
        check("single_data", 32'(reg_w_data), 32'hBEEF);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].valid, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
            claim_en   = tbl[i].ce;
            claim_addr = tbl[i].ca;
            rd_addr_1  = tbl[i].r1;
            rd_addr_2  = tbl[i].r2;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].x_ready));
            check($sformatf("tbl%0d_rd1", i), 32'(rd_busy_1), 32'(tbl[i].x_b1));
            check($sformatf("tbl%0d_rd2", i), 32'(rd_busy_2), 32'(tbl[i].x_b2));
            cycle();
        end
        claim_en = 1'b0;

        // Out-of-range write is accepted but flagged, not written.
        drive(2'b10, 4'd0, 16'h0000, 4'd14, 16'hDEAD);
        #1;
        check("oob_ready", 32'(req_ready), 32'b10);
        cycle();
        check("oob_err", 32'(err_oob),  32'd1);
        check("oob_en",  32'(reg_w_en), 32'd0);
        drive(2'b00, '0, '0, '0, '0);
        cycle();
        check("oob_pulse", 32'(err_oob), 32'd0);

        // Reset while a write is on the port.
        drive(2'b01, 4'd2, 16'h7777, 4'd0, 16'h0000);
        claim_en   = 1'b1;
        claim_addr = 4'd7;
        cycle();
        check("pre_rst_en", 32'(reg_w_en), 32'd1);
        drive(2'b00, '0, '0, '0, '0);
        claim_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_en",   32'(reg_w_en),   32'd0);
        check("midrst_busy", 32'(busy),       32'd0);
        check("midrst_err",  32'(err_oob),    32'd0);
        check("midrst_addr", 32'(reg_w_addr), 32'd0);
        check("midrst_data", 32'(reg_w_data), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Fairness from reset; requester 1 holds its request while blocked.
        fd0    = 16'h1000;
        fd1    = 16'h2000;
        en_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 4'd1, fd0, 4'd2, fd1);
            #1;
            check($sformatf("fair%0d_ready", k), 32'(req_ready), 1 << fair_g[k]);
            cycle();
            if (reg_w_en) en_cnt++;
            if (fair_g[k] == 0) fd0 = fd0 + 16'd1;
            else fd1 = fd1 + 16'd1;
        end
        check("fair_en_count", 32'(en_cnt), 32'd6);
        drive(2'b00, '0, '0, '0, '0);
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
